port_drain_scheduler: RTL

Queue controller and round-robin read scheduler for the three per-port output RAMs of the switch buffer. It owns the write and read pointers of all three RAMs and gates writes when a queue is full. It arbitrates among non-empty queues and drains one word at a time into a single valid/ready stream toward the host read interface. Each returned word is tagged with its source port.

---
 rtl/port_drain_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/port_drain_scheduler.sv
// rtl/port_drain_scheduler.sv - three-port queue pointer controller with round-robin burst drain
module port_drain_scheduler #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                wr_req,
  output logic [2:0]                wr_en,
  output logic [3*ADDR_W-1:0]       wr_addr,
  output logic [2:0]                rd_en,
  output logic [3*ADDR_W-1:0]       rd_addr,
  input  logic [3*DATA_W-1:0]       ram_q,
  input  logic                      enable,
  output logic [DATA_W-1:0]         out_data,
  output logic [1:0]                out_port,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3*(ADDR_W+1)-1:0]   level,
  output logic [2:0]                overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          last_grant_q, last_grant_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic [PW-1:0]       wr_ptr_q [3];
  logic [PW-1:0]       wr_ptr_d [3];
  logic [PW-1:0]       rd_ptr_q [3];
  logic [PW-1:0]       rd_ptr_d [3];
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [1:0]          out_port_q, out_port_d;
  logic                out_valid_q, out_valid_d;
  logic [2:0]          overflow_q, overflow_d;

  logic [2:0]          empty;
  logic [2:0]          full;
  logic                arb_valid;
  logic [1:0]          arb_port;
  logic                grant_empty;
  logic [DATA_W-1:0]   grant_q_data;

  for (genvar g = 0; g < 3; g++) begin : g_port
    assign empty[g] = (wr_ptr_q[g] == rd_ptr_q[g]);
    assign full[g]  = (wr_ptr_q[g][ADDR_W-1:0] == rd_ptr_q[g][ADDR_W-1:0]) &&
                      (wr_ptr_q[g][ADDR_W] != rd_ptr_q[g][ADDR_W]);
    assign wr_addr[g*ADDR_W +: ADDR_W] = wr_ptr_q[g][ADDR_W-1:0];
    assign rd_addr[g*ADDR_W +: ADDR_W] = rd_ptr_q[g][ADDR_W-1:0];
    assign level[g*PW +: PW]           = wr_ptr_q[g] - rd_ptr_q[g];
  end

  assign wr_en     = wr_req & ~full;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

  // Scan farthest-first so the nearest non-empty port after last_grant wins.
  always_comb begin
    arb_valid = 1'b0;
    arb_port  = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (!empty[(int'(last_grant_q) + 1 + k) % 3]) begin
        arb_valid = 1'b1;
        arb_port  = 2'((int'(last_grant_q) + 1 + k) % 3);
      end
    end
  end

  always_comb begin
    grant_empty  = 1'b1;
    grant_q_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q == 2'(i)) begin
        grant_empty  = empty[i];
        grant_q_data = ram_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    out_valid_d  = out_valid_q;
    overflow_d   = overflow_q | (wr_req & full);
    rd_en        = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(wr_en[i]);
      rd_ptr_d[i] = rd_ptr_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (enable && arb_valid) begin
          grant_d      = arb_port;
          last_grant_d = arb_port;
          burst_cnt_d  = 4'd0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        for (int i = 0; i < 3; i++) begin
          rd_en[i] = (grant_q == 2'(i));
        end
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_data_d  = grant_q_data;
        out_port_d  = grant_q;
        out_valid_d = 1'b1;
        burst_cnt_d = burst_cnt_q + 4'd1;
        for (int i = 0; i < 3; i++) begin
          if (grant_q == 2'(i)) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
        end
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (enable && (burst_cnt_q < BMAX) && !grant_empty) state_d = S_ISSUE;
          else                                                state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      burst_cnt_q  <= 4'd0;
      out_data_q   <= '0;
      out_port_q   <= 2'd0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

endmodule
